// File: rtl/dm_pkg.sv
// Shared definitions for the DMI debug module: register addresses, abstract
// command error codes, FSM state types and constant status fields.
package dm_pkg;

  localparam logic [6:0] AddrData0      = 7'h04;
  localparam logic [6:0] AddrData1      = 7'h05;
  localparam logic [6:0] AddrDmcontrol  = 7'h10;
  localparam logic [6:0] AddrDmstatus   = 7'h11;
  localparam logic [6:0] AddrHartinfo   = 7'h12;
  localparam logic [6:0] AddrAbstractcs = 7'h16;
  localparam logic [6:0] AddrCommand    = 7'h17;

  typedef enum logic [2:0] {
    CmdErrNone       = 3'd0,
    CmdErrBusy       = 3'd1,
    CmdErrNotSup     = 3'd2,
    CmdErrExc        = 3'd3,
    CmdErrHaltResume = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {AbsIdle, AbsReq, AbsWait} abs_state_e;
  typedef enum logic {ResIdle, ResReq} res_state_e;

  localparam logic [3:0] DmVersion   = 4'd2;
  localparam logic [3:0] DataCount   = 4'd2;
  localparam logic [4:0] ProgBufSize = 5'd0;

  // Only 32- and 64-bit register accesses are supported.
  function automatic logic aarsize_ok(input logic [2:0] size);
    return (size == 3'd2) || (size == 3'd3);
  endfunction

endpackage

// File: rtl/dmi_debug_module_if.sv
// DMI request/response link between the JTAG DTM (master) and the DM (slave).
interface dmi_debug_module_if;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic        dmi_req_op;
  logic [31:0] dmi_req_data;
  logic        dmi_resp_valid;
  logic [31:0] dmi_resp_data;
  logic        dmi_resp_err;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data,
    input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_err
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data,
    output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_err
  );
endinterface

// File: rtl/dm_abstract_cmd.sv
// Access Register abstract command engine: decodes a command word, reports
// errors and runs the request/response handshake on the hart register port.
module dm_abstract_cmd
  import dm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            clr_i,
  input  logic            cmd_we_i,
  input  logic [31:0]     cmd_i,
  input  logic            halted_i,
  input  logic [31:0]     data0_i,
  input  logic [31:0]     data1_i,
  output logic            busy_o,
  output logic            err_set_o,
  output cmderr_e         err_code_o,
  output logic            data0_we_o,
  output logic            data1_we_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            hart_reg_req_valid_o,
  input  logic            hart_reg_req_ready_i,
  output logic            hart_reg_write_o,
  output logic [15:0]     hart_reg_addr_o,
  output logic [XLEN-1:0] hart_reg_wdata_o,
  input  logic            hart_reg_rvalid_i,
  input  logic [XLEN-1:0] hart_reg_rdata_i,
  input  logic            hart_reg_err_i
);

  abs_state_e  state_q, state_d;
  logic [15:0] regno_q, regno_d;
  logic        write_q, write_d;
  logic        size64_q, size64_d;

  logic unused_cmd;
  assign unused_cmd = ^{cmd_i[23], cmd_i[19:18]};

  // Next-state, error reporting and hart handshake
  always_comb begin
    state_d              = state_q;
    regno_d              = regno_q;
    write_d              = write_q;
    size64_d             = size64_q;
    err_set_o            = 1'b0;
    err_code_o           = CmdErrNone;
    data0_we_o           = 1'b0;
    data1_we_o           = 1'b0;
    hart_reg_req_valid_o = 1'b0;
    if (clr_i) begin
      // Abort drops the request in the same cycle; late responses land in idle.
      state_d = AbsIdle;
    end else begin
      unique case (state_q)
        AbsIdle: begin
          if (cmd_we_i) begin
            if ((cmd_i[31:24] != 8'd0) || !aarsize_ok(cmd_i[22:20])) begin
              err_set_o  = 1'b1;
              err_code_o = CmdErrNotSup;
            end else if (!cmd_i[17]) begin
              // No transfer requested: nothing to do.
            end else if (!halted_i) begin
              err_set_o  = 1'b1;
              err_code_o = CmdErrHaltResume;
            end else begin
              state_d  = AbsReq;
              regno_d  = cmd_i[15:0];
              write_d  = cmd_i[16];
              size64_d = (cmd_i[22:20] == 3'd3);
            end
          end
        end
        AbsReq: begin
          hart_reg_req_valid_o = 1'b1;
          if (hart_reg_req_ready_i) state_d = AbsWait;
        end
        AbsWait: begin
          if (hart_reg_rvalid_i) begin
            if (hart_reg_err_i) begin
              err_set_o  = 1'b1;
              err_code_o = CmdErrExc;
            end else if (!write_q) begin
              data0_we_o = 1'b1;
              data1_we_o = size64_q;
            end
            state_d = AbsIdle;
          end
        end
        default: state_d = AbsIdle;
      endcase
    end
  end

  // Command state registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= AbsIdle;
      regno_q  <= '0;
      write_q  <= 1'b0;
      size64_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      regno_q  <= regno_d;
      write_q  <= write_d;
      size64_q <= size64_d;
    end
  end

  assign busy_o           = (state_q != AbsIdle);
  assign rdata_o          = hart_reg_rdata_i;
  assign hart_reg_write_o = write_q;
  assign hart_reg_addr_o  = regno_q;
  assign hart_reg_wdata_o = size64_q ? {data1_i, data0_i} : {{(XLEN-32){1'b0}}, data0_i};

endmodule

// File: rtl/dmi_debug_module.sv
// RISC-V 0.13 Debug Module DMI responder for a single RV64 hart: register
// file, halt/resume/ndmreset control and abstract command front end.
module dmi_debug_module
  import dm_pkg::*;
#(
  parameter logic [31:0] HARTINFO_VAL = 32'h0,
  parameter int unsigned XLEN         = 64
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               dmi_rstn_i,
  dmi_debug_module_if.slave  dmi,
  output logic               hart_haltreq_o,
  output logic               hart_resumereq_o,
  output logic               hart_ndmreset_o,
  input  logic               hart_halted_i,
  input  logic               hart_running_i,
  output logic               hart_reg_req_valid_o,
  input  logic               hart_reg_req_ready_i,
  output logic               hart_reg_write_o,
  output logic [15:0]        hart_reg_addr_o,
  output logic [XLEN-1:0]    hart_reg_wdata_o,
  input  logic               hart_reg_rvalid_i,
  input  logic [XLEN-1:0]    hart_reg_rdata_i,
  input  logic               hart_reg_err_i
);

  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        haltreq_q, haltreq_d, ndmreset_q, ndmreset_d, dmactive_q, dmactive_d;
  logic        resumeack_q, resumeack_d;
  logic [2:0]  cmderr_q, cmderr_d;
  res_state_e  res_state_q, res_state_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic            clr, acc, wr, rd, busy, busy_hit, cmd_we;
  logic [6:0]      addr;
  logic [31:0]     wdata, rdata;
  logic            abs_err_set, data0_we, data1_we;
  cmderr_e         abs_err_code;
  logic [XLEN-1:0] abs_rdata;

  assign clr   = !dmactive_q || !dmi_rstn_i;
  assign addr  = dmi.dmi_req_addr;
  assign wdata = dmi.dmi_req_data;
  assign acc   = dmi.dmi_req_valid && dmi.dmi_req_ready;
  assign wr    = acc && dmi.dmi_req_op;
  assign rd    = acc && !dmi.dmi_req_op;

  // Abstract-state accesses while a command is in flight are refused.
  assign busy_hit = busy && ((wr && (addr == AddrData0 || addr == AddrData1 ||
                                     addr == AddrAbstractcs || addr == AddrCommand)) ||
                             (rd && (addr == AddrData0 || addr == AddrData1)));
  assign cmd_we   = wr && (addr == AddrCommand) && !busy && (cmderr_q == CmdErrNone) && !clr;

  dm_abstract_cmd #(
    .XLEN (XLEN)
  ) u_abstract_cmd (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .clr_i                (clr),
    .cmd_we_i             (cmd_we),
    .cmd_i                (wdata),
    .halted_i             (hart_halted_i),
    .data0_i              (data0_q),
    .data1_i              (data1_q),
    .busy_o               (busy),
    .err_set_o            (abs_err_set),
    .err_code_o           (abs_err_code),
    .data0_we_o           (data0_we),
    .data1_we_o           (data1_we),
    .rdata_o              (abs_rdata),
    .hart_reg_req_valid_o (hart_reg_req_valid_o),
    .hart_reg_req_ready_i (hart_reg_req_ready_i),
    .hart_reg_write_o     (hart_reg_write_o),
    .hart_reg_addr_o      (hart_reg_addr_o),
    .hart_reg_wdata_o     (hart_reg_wdata_o),
    .hart_reg_rvalid_i    (hart_reg_rvalid_i),
    .hart_reg_rdata_i     (hart_reg_rdata_i),
    .hart_reg_err_i       (hart_reg_err_i)
  );

  // Read mux over the pre-update register state
  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (addr)
        AddrData0:      rdata = busy ? '0 : data0_q;
        AddrData1:      rdata = busy ? '0 : data1_q;
        AddrDmcontrol:  rdata = {haltreq_q, 1'b0, 28'd0, ndmreset_q, dmactive_q};
        AddrDmstatus:   rdata = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                 hart_running_i, hart_running_i, hart_halted_i, hart_halted_i,
                                 1'b1, 3'd0, DmVersion};
        AddrHartinfo:   rdata = HARTINFO_VAL;
        AddrAbstractcs: rdata = {3'd0, ProgBufSize, 11'd0, busy, 1'b0, cmderr_q, 4'd0, DataCount};
        default:        rdata = '0;
      endcase
    end
  end

  // Register file, cmderr and resume FSM next state
  always_comb begin
    data0_d      = data0_q;
    data1_d      = data1_q;
    haltreq_d    = haltreq_q;
    ndmreset_d   = ndmreset_q;
    dmactive_d   = dmactive_q;
    resumeack_d  = resumeack_q;
    cmderr_d     = cmderr_q;
    res_state_d  = res_state_q;
    resp_valid_d = acc;
    resp_data_d  = rdata;

    if (!dmi_rstn_i) dmactive_d = 1'b0;
    else if (wr && addr == AddrDmcontrol) dmactive_d = wdata[0];

    if (clr) begin
      data0_d     = '0;
      data1_d     = '0;
      haltreq_d   = 1'b0;
      ndmreset_d  = 1'b0;
      resumeack_d = 1'b0;
      cmderr_d    = CmdErrNone;
      res_state_d = ResIdle;
    end else begin
      if (wr && addr == AddrDmcontrol) begin
        haltreq_d  = wdata[31];
        ndmreset_d = wdata[1];
      end
      if (wr && !busy) begin
        if (addr == AddrData0) data0_d = wdata;
        if (addr == AddrData1) data1_d = wdata;
        if (addr == AddrAbstractcs) cmderr_d = cmderr_q & ~wdata[10:8];
      end
      if (busy_hit && cmderr_q == CmdErrNone) cmderr_d = CmdErrBusy;
      if (abs_err_set) cmderr_d = abs_err_code;
      if (data0_we) data0_d = abs_rdata[31:0];
      if (data1_we) data1_d = abs_rdata[63:32];

      if (res_state_q == ResReq && hart_running_i && !hart_halted_i) begin
        resumeack_d = 1'b1;
        res_state_d = ResIdle;
      end
      // A resume request alongside a halt request is dropped.
      if (wr && addr == AddrDmcontrol && wdata[30] && !wdata[31]) begin
        resumeack_d = 1'b0;
        res_state_d = ResReq;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data0_q      <= '0;
      data1_q      <= '0;
      haltreq_q    <= 1'b0;
      ndmreset_q   <= 1'b0;
      dmactive_q   <= 1'b0;
      resumeack_q  <= 1'b0;
      cmderr_q     <= CmdErrNone;
      res_state_q  <= ResIdle;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      haltreq_q    <= haltreq_d;
      ndmreset_q   <= ndmreset_d;
      dmactive_q   <= dmactive_d;
      resumeack_q  <= resumeack_d;
      cmderr_q     <= cmderr_d;
      res_state_q  <= res_state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign dmi.dmi_req_ready  = !resp_valid_q;
  assign dmi.dmi_resp_valid = resp_valid_q;
  assign dmi.dmi_resp_data  = resp_data_q;
  assign dmi.dmi_resp_err   = 1'b0;

  assign hart_haltreq_o   = haltreq_q && dmactive_q;
  assign hart_resumereq_o = (res_state_q == ResReq);
  assign hart_ndmreset_o  = ndmreset_q;

endmodule

// File: tb/tb_dmi_debug_module.sv
// Self-checking bench for dmi_debug_module: directed vector table, multi-cycle
// abstract-command/resume sequences, and randomized traffic against a model.
module tb_dmi_debug_module;

  logic        clk = 1'b0;
  logic        rstn, dmi_rstn;
  logic        halted, running, reg_ready, reg_rvalid, reg_err;
  logic [63:0] reg_rdata;
  logic        haltreq, resumereq, ndmreset, reg_valid, reg_write;
  logic [15:0] reg_addr;
  logic [63:0] reg_wdata;

  dmi_debug_module_if dmi ();

  dmi_debug_module #(
    .HARTINFO_VAL (32'h0),
    .XLEN         (64)
  ) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .dmi_rstn_i           (dmi_rstn),
    .dmi                  (dmi),
    .hart_haltreq_o       (haltreq),
    .hart_resumereq_o     (resumereq),
    .hart_ndmreset_o      (ndmreset),
    .hart_halted_i        (halted),
    .hart_running_i       (running),
    .hart_reg_req_valid_o (reg_valid),
    .hart_reg_req_ready_i (reg_ready),
    .hart_reg_write_o     (reg_write),
    .hart_reg_addr_o      (reg_addr),
    .hart_reg_wdata_o     (reg_wdata),
    .hart_reg_rvalid_i    (reg_rvalid),
    .hart_reg_rdata_i     (reg_rdata),
    .hart_reg_err_i       (reg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One DMI transaction; returns the response data sampled in the response cycle.
  task automatic dmi_xfer(input logic op, input logic [6:0] a, input logic [31:0] d,
                          output logic [31:0] rdat);
    @(negedge clk);
    check("req_ready_idle", dmi.dmi_req_ready, 1);
    dmi.dmi_req_valid = 1'b1;
    dmi.dmi_req_op    = op;
    dmi.dmi_req_addr  = a;
    dmi.dmi_req_data  = d;
    @(negedge clk);
    dmi.dmi_req_valid = 1'b0;
    check("resp_valid", dmi.dmi_resp_valid, 1);
    check("req_ready_resp", dmi.dmi_req_ready, 0);
    check("resp_err", dmi.dmi_resp_err, 0);
    if (op) check("resp_data_wr", dmi.dmi_resp_data, 0);
    rdat = dmi.dmi_resp_data;
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] r;
    dmi_xfer(1'b1, a, d, r);
  endtask

  task automatic dmi_rd(input string name, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] r;
    dmi_xfer(1'b0, a, 32'h0, r);
    check(name, r, exp);
  endtask

  // Hart side: wait for a register request, accept it, return one response.
  task automatic hart_serve(input logic [63:0] rdat, input logic err, input logic exp_wr,
                            input logic [15:0] exp_addr);
    int k = 0;
    while (reg_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("hart_req_seen", reg_valid, 1);
    check("hart_req_write", reg_write, exp_wr);
    check("hart_req_addr", reg_addr, exp_addr);
    reg_ready = 1'b1;
    @(negedge clk);
    check("hart_req_drop", reg_valid, 0);
    reg_rvalid = 1'b1;
    reg_rdata  = rdat;
    reg_err    = err;
    @(negedge clk);
    reg_rvalid = 1'b0;
    reg_err    = 1'b0;
  endtask

  typedef struct {
    logic        op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        halted;
    logic        running;
    logic [31:0] exp_data;
    logic        exp_halt;
    logic        exp_ndm;
  } vec_t;

  vec_t tbl[24];

  // Behavioural model of the architectural register state.
  logic [31:0] m_data0, m_data1;
  logic        m_haltreq, m_ndm, m_dmactive, m_ack;
  logic [2:0]  m_cmderr;

  function automatic logic [31:0] model_read(input logic [6:0] a, input logic h, input logic r);
    case (a)
      7'h04:   return m_data0;
      7'h05:   return m_data1;
      7'h10:   return (m_haltreq ? 32'h8000_0000 : 32'h0) | (m_ndm ? 32'h2 : 32'h0) |
                      (m_dmactive ? 32'h1 : 32'h0);
      7'h11:   return (m_ack ? 32'h30000 : 32'h0) | (r ? 32'hC00 : 32'h0) |
                      (h ? 32'h300 : 32'h0) | 32'h80 | 32'h2;
      7'h12:   return 32'h0;
      7'h16:   return 32'h2 + (32'(m_cmderr) * 256);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [31:0] d, input logic h);
    if (!m_dmactive) begin
      if (a == 7'h10) m_dmactive = d[0];
      return;
    end
    case (a)
      7'h04: m_data0 = d;
      7'h05: m_data1 = d;
      7'h10: begin
        m_haltreq  = d[31];
        m_ndm      = d[1];
        m_dmactive = d[0];
        if (!d[0]) begin
          m_data0 = 0; m_data1 = 0; m_haltreq = 0; m_ndm = 0; m_ack = 0; m_cmderr = 0;
        end
      end
      7'h16: m_cmderr = m_cmderr & ~d[10:8];
      7'h17: begin
        if (m_cmderr == 0) begin
          if (d[31:24] != 0 || (d[22:20] != 3'd2 && d[22:20] != 3'd3)) m_cmderr = 3'd2;
          else if (d[17] && !h) m_cmderr = 3'd4;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int high;
    logic [31:0] r;
    rstn = 1'b0; dmi_rstn = 1'b1;
    halted = 1'b0; running = 1'b1;
    reg_ready = 1'b1; reg_rvalid = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    dmi.dmi_req_valid = 1'b0; dmi.dmi_req_op = 1'b0;
    dmi.dmi_req_addr = '0; dmi.dmi_req_data = '0;

    tbl[0]  = '{1'b1, 7'h10, 32'h0000_0001, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b0, 7'h10, 32'h0,         1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 7'h11, 32'h0,         1'b0, 1'b1, 32'h0000_0C82, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 7'h12, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b0, 7'h16, 32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 7'h04, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    tbl[6]  = '{1'b0, 7'h04, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 7'h05, 32'h1234_5678, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    tbl[8]  = '{1'b0, 7'h05, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 7'h17, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    tbl[10] = '{1'b0, 7'h7F, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    tbl[11] = '{1'b1, 7'h10, 32'h8000_0001, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
    tbl[12] = '{1'b0, 7'h10, 32'h0,         1'b1, 1'b0, 32'h8000_0001, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 7'h11, 32'h0,         1'b1, 1'b0, 32'h0000_0382, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 7'h10, 32'h0000_0003, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[15] = '{1'b0, 7'h10, 32'h0,         1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 7'h10, 32'h0000_0001, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[17] = '{1'b1, 7'h7F, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[18] = '{1'b0, 7'h04, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 7'h10, 32'h8000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[20] = '{1'b0, 7'h04, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[21] = '{1'b1, 7'h04, 32'h0000_0011, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[22] = '{1'b1, 7'h10, 32'h8000_0001, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[23] = '{1'b0, 7'h10, 32'h0,         1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};

    // Reset state
    #23;
    check("rst_req_ready", dmi.dmi_req_ready, 1);
    check("rst_resp_valid", dmi.dmi_resp_valid, 0);
    check("rst_resp_data", dmi.dmi_resp_data, 0);
    check("rst_resp_err", dmi.dmi_resp_err, 0);
    check("rst_haltreq", haltreq, 0);
    check("rst_resumereq", resumereq, 0);
    check("rst_ndmreset", ndmreset, 0);
    check("rst_reg_valid", reg_valid, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      halted  = tbl[i].halted;
      running = tbl[i].running;
      dmi_xfer(tbl[i].op, tbl[i].addr, tbl[i].wdata, r);
      if (!tbl[i].op) check($sformatf("vec%0d_data", i), r, tbl[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_haltreq", i), haltreq, tbl[i].exp_halt);
      check($sformatf("vec%0d_ndmreset", i), ndmreset, tbl[i].exp_ndm);
    end

    // Resume handshake: hart takes 5 cycles to start running
    halted = 1'b1; running = 1'b0;
    dmi_wr(7'h10, 32'h4000_0001);
    high = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (resumereq === 1'b1) high++;
    end
    halted = 1'b0; running = 1'b1;
    @(negedge clk);
    check("resume_high_cycles", high, 5);
    check("resumereq_drop", resumereq, 0);
    dmi_rd("dmstatus_resumeack", 7'h11, 32'h0003_0C82);
    dmi_rd("dmcontrol_resume_rd0", 7'h10, 32'h0000_0001);

    // 64-bit register read x1
    halted = 1'b1; running = 1'b0;
    dmi_wr(7'h17, 32'h0032_1001);
    hart_serve(64'h1122_3344_5566_7788, 1'b0, 1'b0, 16'h1001);
    dmi_rd("abs_rd_cs", 7'h16, 32'h0000_0002);
    dmi_rd("abs_rd_data0", 7'h04, 32'h5566_7788);
    dmi_rd("abs_rd_data1", 7'h05, 32'h1122_3344);

    // 64-bit write held off by the hart; accesses while busy
    reg_ready = 1'b0;
    dmi_wr(7'h17, 32'h0033_1002);
    check("abs_wr_valid", reg_valid, 1);
    check("abs_wr_write", reg_write, 1);
    check("abs_wr_wdata", reg_wdata, 64'h1122_3344_5566_7788);
    dmi_wr(7'h04, 32'h0);
    dmi_rd("busy_data0_rd", 7'h04, 32'h0);
    dmi_rd("busy_cs", 7'h16, 32'h0000_1102);
    dmi_wr(7'h16, 32'h0000_0700);
    hart_serve(64'h0, 1'b0, 1'b1, 16'h1002);
    reg_ready = 1'b1;
    dmi_rd("busy_data0_kept", 7'h04, 32'h5566_7788);
    dmi_rd("busy_cmderr_kept", 7'h16, 32'h0000_0102);
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_rd("cmderr_w1c", 7'h16, 32'h0000_0002);

    // Unsupported command type
    dmi_wr(7'h17, 32'h0100_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("notsup_no_req", reg_valid, 0);
    end
    dmi_rd("notsup_cs", 7'h16, 32'h0000_0202);
    dmi_wr(7'h16, 32'h0000_0700);

    // Transfer to a running hart
    halted = 1'b0; running = 1'b1;
    dmi_wr(7'h17, 32'h0022_1001);
    @(negedge clk);
    check("haltresume_no_req", reg_valid, 0);
    dmi_rd("haltresume_cs", 7'h16, 32'h0000_0402);
    dmi_wr(7'h16, 32'h0000_0700);

    // Faulting access, then a 32-bit read
    halted = 1'b1; running = 1'b0;
    dmi_wr(7'h17, 32'h0022_1001);
    hart_serve(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 16'h1001);
    dmi_rd("exc_cs", 7'h16, 32'h0000_0302);
    dmi_rd("exc_data0_kept", 7'h04, 32'h5566_7788);
    dmi_wr(7'h16, 32'h0000_0700);
    dmi_wr(7'h17, 32'h0022_1002);
    hart_serve(64'hCAFE_F00D_0BAD_BEEF, 1'b0, 1'b0, 16'h1002);
    dmi_rd("rd32_data0", 7'h04, 32'h0BAD_BEEF);
    dmi_rd("rd32_data1", 7'h05, 32'h1122_3344);

    // DMI hard reset mid-command, then a stale hart response
    reg_ready = 1'b0;
    dmi_wr(7'h17, 32'h0022_1001);
    check("dmirst_valid_before", reg_valid, 1);
    dmi_rstn = 1'b0;
    #1;
    check("dmirst_valid_same", reg_valid, 0);
    @(negedge clk);
    check("dmirst_valid_next", reg_valid, 0);
    dmi_rstn = 1'b1;
    reg_rvalid = 1'b1; reg_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    reg_rvalid = 1'b0;
    reg_ready  = 1'b1;
    dmi_rd("dmirst_dmcontrol", 7'h10, 32'h0);
    dmi_rd("dmirst_cs", 7'h16, 32'h0000_0002);
    dmi_wr(7'h10, 32'h0000_0001);
    dmi_rd("dmirst_data0", 7'h04, 32'h0);
    dmi_rd("dmirst_data1", 7'h05, 32'h0);

    // Randomized traffic against the model (no hart accesses are started)
    m_data0 = 0; m_data1 = 0; m_haltreq = 0; m_ndm = 0; m_dmactive = 1; m_ack = 0; m_cmderr = 0;
    for (int i = 0; i < 200; i++) begin
      logic [6:0]  a;
      logic [31:0] d;
      logic        op;
      halted  = 1'($urandom_range(0, 1));
      running = 1'($urandom_range(0, 1));
      op      = 1'($urandom_range(0, 1));
      d       = $urandom;
      case ($urandom_range(0, 8))
        0:       a = 7'h04;
        1:       a = 7'h05;
        2, 8:    a = 7'h10;
        3:       a = 7'h11;
        4:       a = 7'h12;
        5:       a = 7'h16;
        6:       a = 7'h17;
        default: a = 7'($urandom);
      endcase
      if (a == 7'h10) begin
        d[30] = 1'b0;
        d[0]  = ($urandom_range(0, 7) != 0);
      end
      if (a == 7'h17 && halted) d[17] = 1'b0;
      dmi_xfer(op, a, d, r);
      if (op) model_write(a, d, halted);
      else check($sformatf("rand%0d_rd_%0h", i, a), r, model_read(a, halted, running));
      @(negedge clk);
      check("rand_haltreq", haltreq, m_haltreq & m_dmactive);
      check("rand_ndmreset", ndmreset, m_ndm);
      check("rand_resumereq", resumereq, 0);
      check("rand_reg_valid", reg_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmi_debug_module.md
Name: dmi_debug_module

Overview:
- DMI responder, the Debug Module side of the DMI link driven by the JTAG DTM; decodes DMI read/write requests against a minimal RISC-V 0.13 DM register set.
- Drives halt/resume/ndmreset to the single RV64 hart and executes Access Register abstract commands through a hart-side register port.
- Sits between the DTM and the core, in the same clock domain.

Parameters:
- HARTINFO_VAL, 32'h0, value returned on reads of hartinfo (0x12).
- XLEN, 64, hart register width; only 64 is supported.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- dmi_rstn_i  in  1  DMI hard reset from DTM, active-low, sampled synchronously
- dmi_req_valid_i  in  1  request valid
- dmi_req_ready_o  out  1  request ready
- dmi_req_addr_i  in  7  register address
- dmi_req_op_i  in  1  1=write, 0=read
- dmi_req_data_i  in  32  write data
- dmi_resp_valid_o  out  1  single-cycle response pulse
- dmi_resp_data_o  out  32  read data, 0 for writes
- dmi_resp_err_o  out  1  always 0; errors are reported via cmderr
- hart_haltreq_o  out  1  halt request level
- hart_resumereq_o  out  1  resume request level
- hart_ndmreset_o  out  1  non-debug-module reset
- hart_halted_i  in  1  hart is halted
- hart_running_i  in  1  hart is running
- hart_reg_req_valid_o  out  1  register access request
- hart_reg_req_ready_i  in  1  hart accepts request
- hart_reg_write_o  out  1  1=write register
- hart_reg_addr_o  out  16  regno
- hart_reg_wdata_o  out  64  write data
- hart_reg_rvalid_i  in  1  access complete; single-cycle pulse
- hart_reg_rdata_i  in  64  read data, valid with rvalid
- hart_reg_err_i  in  1  access faulted, valid with rvalid

Behaviour:
- Reset values: ready_o=1; resp_valid/data/err=0; all hart_* outputs 0; all DM registers 0.
- DMI timing:
  - Request accepted on valid&ready.
  - Response follows exactly 1 cycle later: resp_valid_o=1 for one cycle, with registered read data.
  - ready_o=0 during the response cycle; otherwise 1.
  - Read data reflects register state before any same-cycle update.
- Register map:
  - data0 0x04 and data1 0x05: RW.
  - dmcontrol 0x10:
    - [31] haltreq, RW.
    - [30] resumereq, write-1 pulse, reads 0.
    - [1] ndmreset, RW.
    - [0] dmactive, RW.
  - dmstatus 0x11, RO:
    - [17:16] all/anyresumeack.
    - [11:10] all/anyrunning = running_i.
    - [9:8] all/anyhalted = halted_i.
    - [7] authenticated=1.
    - [3:0] version=2.
  - hartinfo 0x12: RO, returns HARTINFO_VAL.
  - abstractcs 0x16:
    - [28:24] progbufsize=0.
    - [12] busy.
    - [10:8] cmderr, W1C.
    - [3:0] datacount=2.
  - command 0x17: write-only, reads 0.
  - Unmapped addresses read 0; writes to them are ignored.
- dmactive=0 or dmi_rstn_i=0:
  - Synchronously clears data0/1, haltreq, ndmreset, resumeack, cmderr and the abstract FSM.
  - dmi_rstn_i=0 also clears dmactive.
  - While dmactive=0, writes update only dmactive.
- Halt: hart_haltreq_o = haltreq & dmactive.
- Resume FSM, states R_IDLE and R_REQ:
  - Write with resumereq=1 and haltreq=0: clear resumeack, enter R_REQ.
  - R_REQ: hart_resumereq_o=1 until running_i=1 and halted_i=0; then set resumeack and return to R_IDLE.
  - resumereq together with haltreq=1 is ignored.
- Abstract FSM, states A_IDLE, A_REQ, A_WAIT; busy = state != A_IDLE.
- Command write in A_IDLE with cmderr=0 is checked in priority order:
  - cmdtype[31:24]!=0 or aarsize[22:20] not in {2,3}: cmderr=2.
  - transfer[17]=0: completes immediately, no hart access.
  - halted_i=0: cmderr=4.
  - Otherwise enter A_REQ with regno=[15:0] and write=[16].
- Command write with cmderr!=0 is ignored.
- A_REQ:
  - valid_o=1; wdata = aarsize 3 ? {data1,data0} : zero-extended data0.
  - On ready_i, go to A_WAIT.
- A_WAIT, on rvalid_i:
  - err_i=1: cmderr=3, data unchanged.
  - Else, for a read: data0 = rdata[31:0], and data1 = rdata[63:32] only when aarsize=3.
  - Go to A_IDLE.
- While busy, any write to command/abstractcs/data0/data1 or read of data0/data1:
  - The access is ignored and a read returns 0.
  - cmderr is set to 1 if it was 0.
- Other events:
  - Reset mid-command: FSM returns to A_IDLE and valid_o drops in the same cycle.
  - A hart response arriving after the reset is ignored.

Decomposition:
- dm_pkg:
  - Register address localparams.
  - cmderr codes: NONE=0, BUSY=1, NOTSUP=2, EXC=3, HALTRESUME=4.
  - Abstract and resume FSM state enums.
  - dmstatus/abstractcs constant fields.
- Sub-module dm_abstract_cmd: command decode, error checks, hart register handshake, data0/1 update strobes.

Test Plan:
- Read 0x11 with halted_i=0, running_i=1 after dmactive=1: resp 1 cycle later, data=0x00000C82, err=0.
- Write 0x10 data 0x80000001; assert halted_i -> haltreq_o=1; read 0x11 returns bits 9:8 set.
- Halted hart; write 0x10 0x40000001; hart drops halted_i and raises running_i after 5 cycles -> resumereq_o high 5 cycles; dmstatus bits 17:16=11.
- Halted hart; command 0x00321001 (aarsize3, transfer, read x1); hart returns 0x1122334455667788 -> data0=0x55667788, data1=0x11223344, cmderr=0.
- Hold ready_i=0 during a command; write data0 -> data0 unchanged, cmderr=1. Write 0x16 0x700 -> cmderr=0.
- Command 0x01000000 -> cmderr=2, no hart request. Running hart with command 0x00221001 -> cmderr=4. dmi_rstn_i low mid-command -> valid_o=0 next cycle, dmcontrol reads 0.
